alu_issue: RTL
==============

# alu_issue

Registered issue stage between decode and the combinational `alu`. Accepts one decoded operation per cycle over a valid/ready handshake, selects the ALU operands, and drives the ALU. It captures result and flags into a two-entry skid buffer presented to writeback over a second valid/ready handshake. It decouples decode from writeback stalls without a combinational ready path.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, destination register index width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  decoded op present
- `in_ready`  out  1  stage can accept; registered
- `in_op`  in  `alu_ops_e`  ALU operation
- `in_a_sel`  in  `alu_a_sel_e`  A source: `A_RS1`, `A_PC`, `A_ZERO`
- `in_b_sel`  in  `alu_b_sel_e`  B source: `B_RS2`, `B_IMM`, `B_FOUR`
- `in_rs1`, `in_rs2`, `in_imm`, `in_pc`  in  `DATA_WIDTH` each  operand candidates
- `in_rs1_idx`  in  `REG_ADDR_WIDTH`  rs1 index (forwarding only)
- `in_rd`  in  `REG_ADDR_WIDTH`  destination index
- `out_valid`  out  1  result present
- `out_ready`  in  1  writeback accepts
- `out_result`  out  `DATA_WIDTH`  ALU result
- `out_zero`, `out_carry`, `out_overflow`  out  1 each  ALU flags
- `out_rd`  out  `REG_ADDR_WIDTH`  destination index

## Operation
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready`.
- Operands are selected combinationally from the input bus and fed to `alu`. The ALU outputs plus `in_rd` are written into the buffer on the input transfer.
- Operand A: `A_RS1` gives `in_rs1`, `A_PC` gives `in_pc`, `A_ZERO` gives 0. Operand B: `B_RS2` gives `in_rs2`, `B_IMM` gives `in_imm`, `B_FOUR` gives 4.
- Arithmetic wraps modulo 2^`DATA_WIDTH`. Flags are taken from `alu` unchanged. `ALU_NOP` yields result 0 with zero=1.
- The buffer has a head entry (drives `out_*`) and a skid entry.
- FSM states and transitions:
  - `EMPTY`: input transfer goes to `ONE`.
  - `ONE`, with output transfer and input transfer: stays in `ONE`; the new entry becomes the head.
  - `ONE`, with output transfer only: goes to `EMPTY`.
  - `ONE`, with input transfer only: goes to `TWO`; the new entry goes to skid.
  - `TWO`, with output transfer: goes to `ONE`; skid moves to head. An input transfer cannot occur in `TWO`.
- `in_ready` is 1 in `EMPTY`/`ONE` and 0 in `TWO`. It is a registered decode of the next state.
- `out_valid` is 1 in `ONE`/`TWO`.
- Order is strictly FIFO. No entry is dropped or duplicated.
- `out_*` data is stable while `out_valid && !out_ready`.

## Timing
- Latency: input transfer at edge N makes the result visible on `out_*` after edge N (available in cycle N+1) when the buffer was empty.
- Throughput: 1 op/cycle while `out_ready` is held high.
- `in_ready` falls the cycle after the buffer reaches `TWO`. It rises the cycle after an output transfer from `TWO`.
- Reset values, with `rst_n` low at an edge, take effect that edge:
  - state `EMPTY`, `in_ready`=1, `out_valid`=0
  - `out_result`=0, `out_zero`=0, `out_carry`=0, `out_overflow`=0, `out_rd`=0
  - skid entry cleared
- Reset mid-operation discards both entries. A transfer coincident with reset is ignored.
- `in_*` is don't-care when `in_valid`=0. `out_ready` is don't-care when `out_valid`=0.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - If `in_a_sel`=`A_RS1`, `in_rs1_idx`==`out_rd`, `out_rd`!=0 and `out_valid`=1, operand A is replaced by the result of the youngest buffered entry whose `rd` matches: skid if valid and matching, else head.
  - The entry stays in the buffer; this forwards the value only and does not pop it.
- Not defined: operand A is always per `in_a_sel`. The forwarding logic and compare are absent.

## Structure
- Shared package `isa_shared`: `alu_ops_e` (existing), new `alu_a_sel_e` and `alu_b_sel_e`, and the constant `ALU_B_FOUR = 4`.
- The FSM state enum is local to the module.
- Sub-module: the existing `alu`, instantiated once. Buffer and FSM are inline.

## Test plan
- Reset, then `ALU_ADD`, `A_RS1`/`B_RS2`, rs1=5, rs2=7, rd=3, `out_ready`=1 → next cycle `out_valid`=1, result=12, zero=0, rd=3.
- `ALU_ADD` with rs1=0xFFFFFFFF, `B_FOUR` → result=0x00000003, carry=1. `ALU_NOP` → result=0, zero=1.
- Hold `out_ready`=0 and present 3 back-to-back ops (1+1, 2+2, 3+3) → `in_ready`=0 after the 2nd is accepted. Release → results 2, 4, 6 in order; the 3rd is accepted once `in_ready` returns.
- 1000 random ADDs with random `out_ready` → scoreboard matches a+b in order, with no loss or duplication.
- Assert `rst_n`=0 in `TWO` → next cycle `out_valid`=0, `in_ready`=1, `out_result`=0, and no stale result after reset.
- `ALU_ISSUE_FWD_EN`: op rd=4 result 9 buffered with `out_ready`=0, then `ALU_ADD` rs1_idx=4, stale rs1=0, rs2=1 → result 10. Without the macro → result 1.

Source files
------------

// File: rtl/isa_shared_pkg.sv
// Shared ISA-level types used by the decode, issue and execute blocks:
// ALU operation codes, ALU operand source selectors and the constant
// operand used for "PC + 4" style link computations.
package isa_shared;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_ops_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } alu_b_sel_e;

    localparam int unsigned ALU_B_FOUR = 4;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Carry is the unsigned carry-out for ADD and the
// no-borrow indication (a >= b unsigned) for SUB; overflow is the signed
// overflow of ADD/SUB. Logic and shift operations leave both flags at 0.
// Zero reflects the result of every operation, so NOP reports zero=1.
module alu
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_ops_e              op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  carry_o,
    output logic                  overflow_o
);

    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH:0]    sum;
    logic [DATA_WIDTH:0]    diff;
    logic [SHIFT_WIDTH-1:0] shamt;

    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign shamt = b_i[SHIFT_WIDTH-1:0];

    // Select the operation result and its arithmetic flags
    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o   = sum[DATA_WIDTH-1:0];
                carry_o    = sum[DATA_WIDTH];
                overflow_o = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                             (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
            end
            ALU_SUB: begin
                result_o   = diff[DATA_WIDTH-1:0];
                carry_o    = diff[DATA_WIDTH];
                overflow_o = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                             (diff[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRL: result_o = a_i >> shamt;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_issue.sv
// Registered issue stage between decode and the ALU. Selects operands,
// runs the ALU and captures result, flags and rd into a two-entry skid
// buffer (head drives the outputs, skid absorbs one op while writeback
// stalls). in_ready is registered, so decode never sees a combinational
// path from out_ready.
// Optional feature macro: ALU_ISSUE_FWD_EN forwards a buffered result into
// operand A when rs1 names a destination still waiting in the buffer.
module alu_issue
    import isa_shared::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  alu_ops_e                  in_op,
    input  alu_a_sel_e                in_a_sel,
    input  alu_b_sel_e                in_b_sel,
    input  logic [DATA_WIDTH-1:0]     in_rs1,
    input  logic [DATA_WIDTH-1:0]     in_rs2,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_idx,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_zero,
    output logic                      out_carry,
    output logic                      out_overflow,
    output logic [REG_ADDR_WIDTH-1:0] out_rd
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic                      zero;
        logic                      carry;
        logic                      overflow;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } entry_t;

    state_e                state_q;
    state_e                state_d;
    logic                  inReady_q;
    logic                  outValid_q;
    entry_t                head_q;
    entry_t                skid_q;
    entry_t                newEntry;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;
    logic [DATA_WIDTH-1:0] aluResult;
    logic                  aluZero;
    logic                  aluCarry;
    logic                  aluOverflow;
    logic                  inXfer;
    logic                  outXfer;

    assign inXfer  = in_valid && inReady_q;
    assign outXfer = outValid_q && out_ready;

`ifndef ALU_ISSUE_FWD_EN
    logic unusedRs1Idx;
    assign unusedRs1Idx = ^in_rs1_idx;
`endif

    // Pick ALU operands from the decode bus, optionally overriding A with a buffered result
    always_comb begin
        case (in_a_sel)
            A_RS1:   operandA = in_rs1;
            A_PC:    operandA = in_pc;
            default: operandA = '0;
        endcase
`ifdef ALU_ISSUE_FWD_EN
        if ((in_a_sel == A_RS1) && outValid_q && (in_rs1_idx == head_q.rd) &&
            (head_q.rd != '0)) begin
            if ((state_q == TWO) && (skid_q.rd == in_rs1_idx)) begin
                operandA = skid_q.result;
            end else begin
                operandA = head_q.result;
            end
        end
`endif
        case (in_b_sel)
            B_RS2:   operandB = in_rs2;
            B_IMM:   operandB = in_imm;
            B_FOUR:  operandB = DATA_WIDTH'(ALU_B_FOUR);
            default: operandB = '0;
        endcase
    end

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op_i      (in_op),
        .a_i       (operandA),
        .b_i       (operandB),
        .result_o  (aluResult),
        .zero_o    (aluZero),
        .carry_o   (aluCarry),
        .overflow_o(aluOverflow)
    );

    assign newEntry = '{result: aluResult, zero: aluZero, carry: aluCarry,
                        overflow: aluOverflow, rd: in_rd};

    // Buffer occupancy next state from the two handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (inXfer) state_d = ONE;
            ONE: begin
                if (outXfer && !inXfer) begin
                    state_d = EMPTY;
                end else if (inXfer && !outXfer) begin
                    state_d = TWO;
                end
            end
            TWO:     if (outXfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy, registered handshake outputs and head/skid data movement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            inReady_q  <= (state_d != TWO);
            outValid_q <= (state_d != EMPTY);
            case (state_q)
                EMPTY: if (inXfer) head_q <= newEntry;
                ONE: begin
                    if (inXfer && outXfer) begin
                        head_q <= newEntry;
                    end else if (inXfer) begin
                        skid_q <= newEntry;
                    end
                end
                TWO:     if (outXfer) head_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign in_ready     = inReady_q;
    assign out_valid    = outValid_q;
    assign out_result   = head_q.result;
    assign out_zero     = head_q.zero;
    assign out_carry    = head_q.carry;
    assign out_overflow = head_q.overflow;
    assign out_rd       = head_q.rd;

endmodule
